board_view_compositor: RTL and testbench

Parametrised board-view compositor for the Battleship display path. It samples the game-phase enables and the PC and player board matrices once per video frame. It then applies fog-of-war masking to the PC board and overlays a blinking cursor cell. It holds the composed boards stable in registers for the VGA renderer, so the displayed frame never changes mid-scan.

---
 rtl/board_view_compositor.sv | 142 ++++++++++++++
 tb/tb_board_view_compositor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/board_view_compositor.sv
// Board-view compositor: once per video frame, picks the display mode, masks the PC
// fleet, overlays a blinking cursor and freezes both boards for the VGA renderer.
module board_view_compositor #(
    parameter int N            = 5,
    parameter int CW           = 4,
    parameter int SHIP_MAX     = 5,
    parameter int CURSOR_CODE  = 9,
    parameter int BLINK_FRAMES = 16,
    localparam int PW          = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           en_put_barcos,
    input  logic                           en_attack,
    input  logic                           en_pc_attack,
    input  logic                           en_check_pc_life,
    input  logic                           en_check_player_life,
    input  logic                           dead_pc,
    input  logic                           dead_player,
    input  logic [N-1:0][N-1:0][CW-1:0]    matriz_pc,
    input  logic [N-1:0][N-1:0][CW-1:0]    matriz_player,
    input  logic [N-1:0][N-1:0][CW-1:0]    matriz_pc_temp,
    input  logic [N-1:0][N-1:0][CW-1:0]    matriz_player_temp,
    input  logic [PW-1:0]                  posicion_x_move,
    input  logic [PW-1:0]                  posicion_y_move,
    input  logic [PW-1:0]                  posicion_x_attack,
    input  logic [PW-1:0]                  posicion_y_attack,
    output logic [N-1:0][N-1:0][CW-1:0]    matriz_pc_final,
    output logic [N-1:0][N-1:0][CW-1:0]    matriz_player_final,
    output logic [2:0]                     view_mode,
    output logic                           cursor_on,
    output logic                           snapshot_valid
);
    localparam int CNTW = $clog2(BLINK_FRAMES);

    typedef enum logic [2:0] {
        M_IDLE    = 3'd0,
        M_PLACE   = 3'd1,
        M_ATTACK  = 3'd2,
        M_PC_TURN = 3'd3,
        M_END     = 3'd4
    } mode_t;

    mode_t                        mode_q, mode_d, dec_mode;
    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic                         cur_on_d;
    logic                         valid_q, valid_d;
    logic [N-1:0][N-1:0][CW-1:0]  pc_q, pc_d, pl_q, pl_d;
    logic [CW-1:0]                pc_cell, pl_cell;
    logic                         at_move, at_attack;

    function automatic logic is_ship(input logic [CW-1:0] code);
        return (code != '0) && (int'(code) <= SHIP_MAX);
    endfunction

    function automatic logic [CW-1:0] fog(input logic [CW-1:0] code);
        return is_ship(code) ? '0 : code;
    endfunction

    always_comb begin
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        cur_on_d = 1'b0;
        valid_d  = valid_q;
        pc_d     = pc_q;
        pl_d     = pl_q;
        dec_mode = M_IDLE;
        pc_cell  = '0;
        pl_cell  = '0;
        at_move  = 1'b0;
        at_attack = 1'b0;
        if (frame_start) begin
            if (dead_pc || dead_player)                    dec_mode = M_END;
            else if (en_put_barcos)                        dec_mode = M_PLACE;
            else if (en_attack || en_check_pc_life)        dec_mode = M_ATTACK;
            else if (en_pc_attack || en_check_player_life) dec_mode = M_PC_TURN;
            // END only releases into a fresh placement phase
            mode_d = (mode_q == M_END && dec_mode != M_PLACE) ? M_END : dec_mode;
            if (mode_d != mode_q || cnt_q == CNTW'(BLINK_FRAMES - 1))
                cnt_d = '0;
            else
                cnt_d = cnt_q + CNTW'(1);
            cur_on_d = (cnt_d < CNTW'(BLINK_FRAMES / 2));
            valid_d  = 1'b1;
            for (int y = 0; y < N; y++) begin
                for (int x = 0; x < N; x++) begin
                    at_move   = cur_on_d && (posicion_y_move == PW'(y)) &&
                                (posicion_x_move == PW'(x));
                    at_attack = cur_on_d && (posicion_y_attack == PW'(y)) &&
                                (posicion_x_attack == PW'(x));
                    pc_cell = '0;
                    pl_cell = '0;
                    case (mode_d)
                        M_PLACE: begin
                            pc_cell = matriz_pc_temp[y][x];
                            pl_cell = at_move ? CW'(CURSOR_CODE) : matriz_player_temp[y][x];
                        end
                        M_ATTACK: begin
                            pc_cell = at_attack ? CW'(CURSOR_CODE) : fog(matriz_pc[y][x]);
                            pl_cell = matriz_player[y][x];
                        end
                        M_PC_TURN: begin
                            pc_cell = fog(matriz_pc[y][x]);
                            pl_cell = matriz_player[y][x];
                        end
                        M_END: begin
                            pc_cell = matriz_pc[y][x];
                            pl_cell = matriz_player[y][x];
                        end
                        default: ;
                    endcase
                    pc_d[y][x] = pc_cell;
                    pl_d[y][x] = pl_cell;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= M_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            pl_q    <= '0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pl_q    <= pl_d;
        end
    end

    assign matriz_pc_final     = pc_q;
    assign matriz_player_final = pl_q;
    assign view_mode           = mode_q;
    assign cursor_on           = (cnt_q < CNTW'(BLINK_FRAMES / 2));
    assign snapshot_valid      = valid_q;

endmodule

// File: tb/tb_board_view_compositor.sv
// Randomized bench for board_view_compositor against a frame-level reference model.
module tb_board_view_compositor;
    localparam int N = 5, CW = 4, SHIP_MAX = 5, CURSOR_CODE = 9, BF = 16, PW = 3;
    typedef logic [N-1:0][N-1:0][CW-1:0] board_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic frame_start = 1'b0;
    logic en_put, en_att, en_pcatt, en_chkpc, en_chkpl, dead_pc, dead_pl;
    board_t m_pc, m_pl, m_pc_t, m_pl_t, pc_fin, pl_fin;
    logic [PW-1:0] mx, my, ax, ay;
    logic [2:0] view_mode;
    logic cursor_on, snapshot_valid;

    int vectors = 0, miscompares = 0;
    int m_mode, m_cnt, m_valid;
    board_t exp_pc, exp_pl;

    always #5 clk = ~clk;

    board_view_compositor #(.N(N), .CW(CW), .SHIP_MAX(SHIP_MAX), .CURSOR_CODE(CURSOR_CODE),
                            .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .en_put_barcos(en_put), .en_attack(en_att), .en_pc_attack(en_pcatt),
        .en_check_pc_life(en_chkpc), .en_check_player_life(en_chkpl),
        .dead_pc(dead_pc), .dead_player(dead_pl),
        .matriz_pc(m_pc), .matriz_player(m_pl),
        .matriz_pc_temp(m_pc_t), .matriz_player_temp(m_pl_t),
        .posicion_x_move(mx), .posicion_y_move(my),
        .posicion_x_attack(ax), .posicion_y_attack(ay),
        .matriz_pc_final(pc_fin), .matriz_player_final(pl_fin),
        .view_mode(view_mode), .cursor_on(cursor_on), .snapshot_valid(snapshot_valid)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_valid = 0; exp_pc = '0; exp_pl = '0;
    endtask

    // One displayed frame, computed from the game rules on the current inputs.
    task automatic model_frame();
        int want, nxt, c, p;
        bit on;
        if (dead_pc || dead_pl) want = 4;
        else if (en_put) want = 1;
        else if (en_att || en_chkpc) want = 2;
        else if (en_pcatt || en_chkpl) want = 3;
        else want = 0;
        nxt = (m_mode == 4 && want != 1) ? 4 : want;
        m_cnt = (nxt != m_mode) ? 0 : (m_cnt + 1) % BF;
        m_mode = nxt;
        on = (m_cnt < BF / 2);
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                c = 0; p = 0;
                if (m_mode == 1) begin
                    c = int'(m_pc_t[y][x]); p = int'(m_pl_t[y][x]);
                    if (on && int'(mx) == x && int'(my) == y) p = CURSOR_CODE;
                end else if (m_mode == 2 || m_mode == 3) begin
                    c = int'(m_pc[y][x]); p = int'(m_pl[y][x]);
                    if (c >= 1 && c <= SHIP_MAX) c = 0;
                    if (m_mode == 2 && on && int'(ax) == x && int'(ay) == y) c = CURSOR_CODE;
                end else if (m_mode == 4) begin
                    c = int'(m_pc[y][x]); p = int'(m_pl[y][x]);
                end
                exp_pc[y][x] = CW'(c);
                exp_pl[y][x] = CW'(p);
            end
        end
        m_valid = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mode"}, 128'(view_mode), 128'(m_mode));
        chk({tag, ".cursor_on"}, 128'(cursor_on), 128'(m_cnt < BF / 2));
        chk({tag, ".valid"}, 128'(snapshot_valid), 128'(m_valid));
        chk({tag, ".pc"}, 128'(pc_fin), 128'(exp_pc));
        chk({tag, ".player"}, 128'(pl_fin), 128'(exp_pl));
    endtask

    // Called right after a falling edge; each high cycle of frame_start is a frame.
    task automatic do_frames(input int k);
        frame_start = 1'b1;
        repeat (k) begin
            @(negedge clk);
            model_frame();
        end
        frame_start = 1'b0;
    endtask

    task automatic set_en(input logic put, att, pcatt, chkpc, chkpl, dpc, dpl);
        en_put = put; en_att = att; en_pcatt = pcatt; en_chkpc = chkpc;
        en_chkpl = chkpl; dead_pc = dpc; dead_pl = dpl;
    endtask

    task automatic rand_boards();
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                m_pc[y][x]   = CW'($urandom_range(0, 15));
                m_pl[y][x]   = CW'($urandom_range(0, 15));
                m_pc_t[y][x] = CW'($urandom_range(0, 15));
                m_pl_t[y][x] = CW'($urandom_range(0, 15));
            end
        end
        mx = PW'($urandom_range(0, 7)); my = PW'($urandom_range(0, 7));
        ax = PW'($urandom_range(0, 7)); ay = PW'($urandom_range(0, 7));
    endtask

    task automatic rand_inputs();
        rand_boards();
        set_en($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    endtask

    initial begin
        int n9;
        set_en(0, 0, 0, 0, 0, 0, 0);
        m_pc = '0; m_pl = '0; m_pc_t = '0; m_pl_t = '0;
        mx = '0; my = '0; ax = '0; ay = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        do_frames(1);
        check_all("idle");
        chk("idle.valid_const", 128'(snapshot_valid), 128'(1));

        m_pl_t = '0;
        m_pl_t[3][2] = 4'd3; m_pl_t[3][3] = 4'd3; m_pl_t[3][4] = 4'd3;
        mx = 3'd1; my = 3'd1;
        set_en(1, 0, 0, 0, 0, 0, 0);
        do_frames(1);
        check_all("place1");
        chk("place1.cursor_cell", 128'(pl_fin[1][1]), 128'(9));
        chk("place1.ship_cell", 128'(pl_fin[3][4]), 128'(3));
        chk("place1.mode_const", 128'(view_mode), 128'(1));
        for (int f = 2; f <= 17; f++) begin
            do_frames(1);
            check_all($sformatf("blink%0d", f));
            chk($sformatf("blink%0d.on", f), 128'(cursor_on), 128'(f <= 8 || f == 17));
            chk($sformatf("blink%0d.cell", f), 128'(pl_fin[1][1]), (f <= 8 || f == 17) ? 128'(9) : 128'(0));
        end

        m_pc = '0; m_pc[2][2] = 4'd1; m_pc[2][3] = 4'd8;
        ax = 3'd4; ay = 3'd0;
        set_en(0, 1, 0, 0, 0, 0, 0);
        do_frames(1);
        check_all("attack");
        chk("attack.masked", 128'(pc_fin[2][2]), 128'(0));
        chk("attack.above_max", 128'(pc_fin[2][3]), 128'(8));
        chk("attack.cursor", 128'(pc_fin[0][4]), 128'(9));
        ax = 3'd7; ay = 3'd7;
        do_frames(1);
        check_all("attack_oob");
        n9 = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (pc_fin[y][x] == 4'd9) n9++;
        chk("attack_oob.no_cursor", 128'(n9), 128'(0));

        set_en(0, 1, 0, 0, 0, 1, 0);
        do_frames(1);
        check_all("end");
        chk("end.revealed", 128'(pc_fin[2][2]), 128'(1));
        set_en(0, 1, 0, 0, 0, 0, 0);
        do_frames(1);
        check_all("end_sticky");
        chk("end_sticky.mode", 128'(view_mode), 128'(4));
        set_en(1, 0, 0, 0, 0, 0, 0);
        do_frames(1);
        check_all("end_exit");
        chk("end_exit.mode", 128'(view_mode), 128'(1));

        rand_inputs();
        repeat (5) @(negedge clk);
        check_all("hold");

        for (int i = 0; i < 150; i++) begin
            rand_inputs();
            do_frames(($urandom_range(0, 9) == 0) ? 3 : 1);
            check_all($sformatf("rand%0d", i));
            rand_inputs();
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check_all($sformatf("rhold%0d", i));
        end

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        rand_inputs();
        repeat (3) @(negedge clk);
        check_all("rst_hold");
        do_frames(1);
        check_all("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
